// File: rtl/uart_tx_packetizer_if.sv
// Result-word handshake between the arithmetic core and the UART packetizer.
interface uart_tx_packetizer_if #(
    parameter int unsigned NBYTES = 4
) ();
    logic                  resValid;
    logic [8*NBYTES-1:0]   resData;
    logic                  resReady;

    modport master (output resValid, output resData, input resReady);
    modport slave  (input resValid, input resData, output resReady);
endinterface

// File: rtl/uart_tx_packetizer.sv
// Serialises one result word into a UART byte frame: optional header, data MSB first,
// optional XOR checksum. One start request per byte, each gated by the previous byte's done.
module uart_tx_packetizer #(
    parameter int unsigned NBYTES      = 4,
    parameter bit          HEADER_EN   = 1'b1,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    uart_tx_packetizer_if.slave  res,
    output logic                 oTxStart,
    output logic [7:0]           oTxByte,
    input  logic                 iTxBusy,
    input  logic                 iTxDone,
    output logic                 oBusy,
    output logic                 oFrameDone
);
    localparam int unsigned Width   = 8 * NBYTES;
    localparam int unsigned Len     = 32'(HEADER_EN) + NBYTES + 32'(CHECKSUM_EN);
    localparam logic [4:0]  LastIdx = 5'(Len - 1);

    typedef enum logic [2:0] {sIDLE, sLOAD, sWAIT, sNEXT, sDONE} stateE;

    stateE              state;
    logic [Width-1:0]   shiftReg;
    logic [4:0]         idx;
    logic [7:0]         checksum;
    logic               resReady;

    logic               sentData;
    logic               sendingChecksum;
    logic [4:0]         nextIdx;
    logic [Width-1:0]   nextShift;
    logic [7:0]         nextByte;
    logic [7:0]         firstByte;

    assign res.resReady = resReady;

    always_comb begin
        sendingChecksum = CHECKSUM_EN && (idx == LastIdx);
        sentData        = !(HEADER_EN && (idx == 5'd0)) && !sendingChecksum;
        nextIdx         = idx + 5'd1;
        nextShift       = sentData ? (shiftReg << 8) : shiftReg;
        // The checksum register already holds every byte issued so far in this frame.
        if (CHECKSUM_EN && (nextIdx == LastIdx)) begin
            nextByte = checksum;
        end else begin
            nextByte = nextShift[Width-1 -: 8];
        end
        firstByte = HEADER_EN ? HEADER_BYTE : res.resData[Width-1 -: 8];
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state      <= sIDLE;
            shiftReg   <= '0;
            idx        <= '0;
            checksum   <= '0;
            oTxStart   <= 1'b0;
            oTxByte    <= '0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
            resReady   <= 1'b1;
        end else begin
            oTxStart   <= 1'b0;
            oFrameDone <= 1'b0;
            case (state)
                sIDLE: begin
                    if (res.resValid) begin
                        shiftReg <= res.resData;
                        checksum <= '0;
                        idx      <= '0;
                        oTxByte  <= firstByte;
                        oBusy    <= 1'b1;
                        resReady <= 1'b0;
                        state    <= sLOAD;
                    end
                end
                sLOAD: begin
                    if (!iTxBusy) begin
                        oTxStart <= 1'b1;
                        if (!sendingChecksum) begin
                            checksum <= checksum ^ oTxByte;
                        end
                        state <= sWAIT;
                    end
                end
                sWAIT: begin
                    if (iTxDone) begin
                        state <= sNEXT;
                    end
                end
                sNEXT: begin
                    if (idx == LastIdx) begin
                        oFrameDone <= 1'b1;
                        state      <= sDONE;
                    end else begin
                        idx      <= nextIdx;
                        shiftReg <= nextShift;
                        oTxByte  <= nextByte;
                        state    <= sLOAD;
                    end
                end
                sDONE: begin
                    oBusy    <= 1'b0;
                    resReady <= 1'b1;
                    state    <= sIDLE;
                end
                default: begin
                    state      <= sIDLE;
                    shiftReg   <= '0;
                    idx        <= '0;
                    checksum   <= '0;
                    oTxStart   <= 1'b0;
                    oTxByte    <= '0;
                    oBusy      <= 1'b0;
                    oFrameDone <= 1'b0;
                    resReady   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_packetizer.sv
// Scoreboard bench: expected line bytes are queued when a word is offered and popped per oTxStart.
module tb_uart_tx_packetizer;
    localparam int ByteTime = 10;
    localparam int Limit    = 400;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    uart_tx_packetizer_if #(.NBYTES(4)) resA ();
    uart_tx_packetizer_if #(.NBYTES(1)) resB ();

    logic       txStartA, txBusyA, txDoneA, busyA, frameDoneA;
    logic [7:0] txByteA;
    logic       txStartB, txBusyB, txDoneB, busyB, frameDoneB;
    logic [7:0] txByteB;

    logic modelBusy, modelDone;
    logic forceBusy  = 1'b0;
    logic injectDone = 1'b0;
    int   modelCnt;

    assign txBusyA = modelBusy | forceBusy;
    assign txDoneA = modelDone | injectDone;
    assign txBusyB = 1'b0;

    uart_tx_packetizer dutA (
        .iClk(clk), .iRstN(rstN), .res(resA),
        .oTxStart(txStartA), .oTxByte(txByteA), .iTxBusy(txBusyA), .iTxDone(txDoneA),
        .oBusy(busyA), .oFrameDone(frameDoneA)
    );

    uart_tx_packetizer #(.NBYTES(1), .HEADER_EN(1'b0), .HEADER_BYTE(8'hA5), .CHECKSUM_EN(1'b0)) dutB (
        .iClk(clk), .iRstN(rstN), .res(resB),
        .oTxStart(txStartB), .oTxByte(txByteB), .iTxBusy(txBusyB), .iTxDone(txDoneB),
        .oBusy(busyB), .oFrameDone(frameDoneB)
    );

    // Behavioural uart_tx: busy for ByteTime cycles after a start, then a one-cycle done.
    always @(posedge clk) begin
        modelDone <= 1'b0;
        if (!rstN) begin
            modelBusy <= 1'b0;
            modelCnt  <= 0;
        end else if (txStartA && !modelBusy) begin
            modelBusy <= 1'b1;
            modelCnt  <= ByteTime;
        end else if (modelBusy) begin
            if (modelCnt == 1) begin
                modelBusy <= 1'b0;
                modelDone <= 1'b1;
            end
            modelCnt <= modelCnt - 1;
        end
    end

    int nPass = 0;
    int nChecks = 0;
    int startCount = 0;
    int startCountB = 0;
    int frameDoneCount = 0;
    logic [7:0] expQ[$];
    logic [7:0] monExp;

    initial begin
        forever begin
            @(negedge clk);
            if (rstN && txStartA) begin
                startCount++;
                nChecks++;
                if (expQ.size() == 0) begin
                    $display("FAIL unexpected_start got=%h want=none", txByteA);
                end else begin
                    monExp = expQ.pop_front();
                    if (txByteA !== monExp) $display("FAIL line_byte got=%h want=%h", txByteA, monExp);
                    else nPass++;
                end
            end
            if (rstN && txStartB) startCountB++;
            if (rstN && frameDoneA) begin
                frameDoneCount++;
                nChecks++;
                if (resA.resReady !== 1'b0) $display("FAIL ready_in_done got=%b want=0", resA.resReady);
                else nPass++;
            end
        end
    end

    task automatic push_frame(input logic [31:0] word);
        logic [7:0] csum;
        logic [7:0] b;
        csum = 8'hA5;
        expQ.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) begin
            b = word[8*i +: 8];
            expQ.push_back(b);
            csum = csum ^ b;
        end
        expQ.push_back(csum);
    endtask

    // Offers a word and withdraws it after the accepting edge; called just after a negedge.
    task automatic send_word(input logic [31:0] word);
        bit ok;
        ok = 0;
        resA.resData  = word;
        resA.resValid = 1'b1;
        for (int i = 0; i < Limit; i++) begin
            if (resA.resReady === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        resA.resValid = 1'b0;
        nChecks++;
        if (!ok) $display("FAIL accept_timeout got=0 want=1"); else nPass++;
    endtask

    task automatic wait_frame_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < Limit && !seen; i++) begin
            @(negedge clk);
            if (frameDoneA) seen = 1;
        end
        nChecks++;
        if (!seen) $display("FAIL frame_done_timeout got=0 want=1"); else nPass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++; if (txStartA !== 1'b0) $display("FAIL rst_start got=%b want=0", txStartA); else nPass++;
        nChecks++; if (txByteA !== 8'h00) $display("FAIL rst_byte got=%h want=00", txByteA); else nPass++;
        nChecks++; if (busyA !== 1'b0) $display("FAIL rst_busy got=%b want=0", busyA); else nPass++;
        nChecks++; if (frameDoneA !== 1'b0) $display("FAIL rst_fdone got=%b want=0", frameDoneA); else nPass++;
        nChecks++; if (resA.resReady !== 1'b1) $display("FAIL rst_ready got=%b want=1", resA.resReady); else nPass++;
        nChecks++; if (resB.resReady !== 1'b1) $display("FAIL rst_readyB got=%b want=1", resB.resReady); else nPass++;
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame();
        int s0, f0;
        s0 = startCount;
        f0 = frameDoneCount;
        push_frame(32'h12345678);
        send_word(32'h12345678);
        wait_frame_done();
        nChecks++; if (startCount - s0 != 6) $display("FAIL t1_starts got=%0d want=6", startCount - s0); else nPass++;
        nChecks++; if (frameDoneCount - f0 != 1) $display("FAIL t1_fdone got=%0d want=1", frameDoneCount - f0); else nPass++;
        nChecks++; if (expQ.size() != 0) $display("FAIL t1_left got=%0d want=0", expQ.size()); else nPass++;
        nChecks++; if (busyA !== 1'b0) $display("FAIL t1_busy got=%b want=0", busyA); else nPass++;
    endtask

    task automatic test_single_byte();
        bit seen;
        seen = 0;
        resB.resData  = 8'h3C;
        resB.resValid = 1'b1;
        @(negedge clk);
        resB.resValid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (txStartB) seen = 1;
        end
        nChecks++; if (!seen) $display("FAIL t2_start got=0 want=1"); else nPass++;
        nChecks++; if (txByteB !== 8'h3C) $display("FAIL t2_byte got=%h want=3c", txByteB); else nPass++;
        repeat (4) @(negedge clk);
        txDoneB = 1'b1;
        @(negedge clk);
        txDoneB = 1'b0;
        nChecks++; if (frameDoneB !== 1'b0) $display("FAIL t2_fdone_early got=%b want=0", frameDoneB); else nPass++;
        @(negedge clk);
        nChecks++; if (frameDoneB !== 1'b1) $display("FAIL t2_fdone got=%b want=1", frameDoneB); else nPass++;
        @(negedge clk);
        nChecks++; if (frameDoneB !== 1'b0) $display("FAIL t2_fdone_len got=%b want=0", frameDoneB); else nPass++;
        nChecks++; if (busyB !== 1'b0) $display("FAIL t2_busy got=%b want=0", busyB); else nPass++;
        repeat (5) @(negedge clk);
        nChecks++; if (startCountB != 1) $display("FAIL t2_starts got=%0d want=1", startCountB); else nPass++;
    endtask

    task automatic test_back_to_back();
        int s0, f0;
        bit ok;
        s0 = startCount;
        f0 = frameDoneCount;
        push_frame(32'h00000001);
        push_frame(32'hFFFFFFFF);
        resA.resData  = 32'h00000001;
        resA.resValid = 1'b1;
        for (int i = 0; i < Limit && resA.resReady !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        resA.resData = 32'hFFFFFFFF;
        nChecks++; if (resA.resReady !== 1'b0) $display("FAIL t3_ready got=%b want=0", resA.resReady); else nPass++;
        ok = 0;
        for (int i = 0; i < Limit; i++) begin
            if (resA.resReady === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        nChecks++; if (!ok) $display("FAIL t3_accept2 got=0 want=1"); else nPass++;
        nChecks++; if (frameDoneCount - f0 != 1) $display("FAIL t3_order got=%0d want=1", frameDoneCount - f0); else nPass++;
        @(negedge clk);
        resA.resValid = 1'b0;
        wait_frame_done();
        nChecks++; if (startCount - s0 != 12) $display("FAIL t3_starts got=%0d want=12", startCount - s0); else nPass++;
        nChecks++; if (expQ.size() != 0) $display("FAIL t3_left got=%0d want=0", expQ.size()); else nPass++;
    endtask

    task automatic test_busy_stall();
        int s0;
        push_frame(32'hDEADBEEF);
        forceBusy = 1'b1;
        send_word(32'hDEADBEEF);
        s0 = startCount;
        repeat (20) @(negedge clk);
        nChecks++; if (startCount != s0) $display("FAIL t4_stall got=%0d want=0", startCount - s0); else nPass++;
        nChecks++; if (busyA !== 1'b1) $display("FAIL t4_busy got=%b want=1", busyA); else nPass++;
        forceBusy = 1'b0;
        @(negedge clk);
        nChecks++; if (txStartA !== 1'b1) $display("FAIL t4_release got=%b want=1", txStartA); else nPass++;
        wait_frame_done();
        nChecks++; if (expQ.size() != 0) $display("FAIL t4_left got=%0d want=0", expQ.size()); else nPass++;
    endtask

    task automatic test_reset_midframe();
        int s0, s1;
        s0 = startCount;
        push_frame(32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        for (int i = 0; i < Limit && startCount - s0 < 3; i++) @(negedge clk);
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        nChecks++; if (txStartA !== 1'b0) $display("FAIL t5_start got=%b want=0", txStartA); else nPass++;
        nChecks++; if (busyA !== 1'b0) $display("FAIL t5_busy got=%b want=0", busyA); else nPass++;
        nChecks++; if (frameDoneA !== 1'b0) $display("FAIL t5_fdone got=%b want=0", frameDoneA); else nPass++;
        nChecks++; if (resA.resReady !== 1'b1) $display("FAIL t5_ready got=%b want=1", resA.resReady); else nPass++;
        rstN = 1'b1;
        expQ.delete();
        s1 = startCount;
        repeat (40) @(negedge clk);
        nChecks++; if (startCount != s1) $display("FAIL t5_abandon got=%0d want=0", startCount - s1); else nPass++;
        push_frame(32'h0BADF00D);
        send_word(32'h0BADF00D);
        wait_frame_done();
        nChecks++; if (startCount - s1 != 6) $display("FAIL t5_starts got=%0d want=6", startCount - s1); else nPass++;
        nChecks++; if (expQ.size() != 0) $display("FAIL t5_left got=%0d want=0", expQ.size()); else nPass++;
    endtask

    task automatic test_spurious();
        int s0;
        s0 = startCount;
        injectDone = 1'b1;
        @(negedge clk);
        injectDone = 1'b0;
        @(negedge clk);
        nChecks++; if (busyA !== 1'b0) $display("FAIL t6_idle_busy got=%b want=0", busyA); else nPass++;
        nChecks++; if (resA.resReady !== 1'b1) $display("FAIL t6_idle_ready got=%b want=1", resA.resReady); else nPass++;
        push_frame(32'h5A5A0FF0);
        send_word(32'h5A5A0FF0);
        for (int i = 0; i < Limit && startCount == s0; i++) @(negedge clk);
        resA.resData  = 32'hFFFFFFFF;
        resA.resValid = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++; if (resA.resReady !== 1'b0) $display("FAIL t6_wait_ready got=%b want=0", resA.resReady); else nPass++;
        resA.resValid = 1'b0;
        wait_frame_done();
        repeat (20) @(negedge clk);
        nChecks++; if (startCount - s0 != 6) $display("FAIL t6_starts got=%0d want=6", startCount - s0); else nPass++;
        nChecks++; if (expQ.size() != 0) $display("FAIL t6_left got=%0d want=0", expQ.size()); else nPass++;
        nChecks++; if (busyA !== 1'b0) $display("FAIL t6_busy got=%b want=0", busyA); else nPass++;
    endtask

    initial begin
        resA.resValid = 1'b0;
        resA.resData  = '0;
        resB.resValid = 1'b0;
        resB.resData  = '0;
        txDoneB       = 1'b0;
        test_reset();
        test_frame();
        test_single_byte();
        test_back_to_back();
        test_busy_stall();
        test_reset_midframe();
        test_spurious();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench did not finish");
    end
endmodule
